// File: rtl/serial_addsub_ctrl_if.sv
// -----------------------------------------------------------------------------
// serial_addsub_ctrl_if
//   Groups the request and result handshake signals of the bit-serial
//   add/subtract engine.
//
//   Request side : start_valid, start_ready, a_in, b_in, control
//   Result side  : res_valid, res_ready, sum_out, cout_out, ovf_out
//   Status       : busy
//
//   The master modport is the requester/consumer. The slave modport is the engine.
// -----------------------------------------------------------------------------
interface serial_addsub_ctrl_if #(
    parameter int WIDTH = 4
);
    logic             start_valid;
    logic             start_ready;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             control;
    logic             busy;
    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] sum_out;
    logic             cout_out;
    logic             ovf_out;

    modport master (
        output start_valid, a_in, b_in, control, res_ready,
        input  start_ready, busy, res_valid, sum_out, cout_out, ovf_out
    );

    modport slave (
        input  start_valid, a_in, b_in, control, res_ready,
        output start_ready, busy, res_valid, sum_out, cout_out, ovf_out
    );
endinterface

// File: rtl/serial_addsub_ctrl.sv
// -----------------------------------------------------------------------------
// serial_addsub_ctrl
//   Bit-serial add/subtract engine. WIDTH-bit operands are accepted through a
//   valid/ready handshake. They are processed LSB-first through a single
//   full-adder cell, one bit per clock. The sum, the carry-out and the signed
//   overflow are returned through a second valid/ready handshake.
//   control=0 selects A+B. control=1 selects A-B, computed as A + ~B + 1.
//
//   Ports
//     clk    : rising-edge clock
//     rst_n  : asynchronous active-low reset
//     bus    : serial_addsub_ctrl_if.slave
//              (start_valid/start_ready/a_in/b_in/control in,
//               res_valid/res_ready/sum_out/cout_out/ovf_out out, busy)
//
//   FSM: IDLE -> SHIFT (WIDTH cycles) -> DONE (until res_ready) -> IDLE.
//   All outputs are registered.
// -----------------------------------------------------------------------------
module serial_addsub_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    serial_addsub_ctrl_if.slave  bus
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_sh_q;
    logic [WIDTH-1:0] b_sh_q;
    logic [WIDTH-1:0] psum_q;
    logic             carry_q;
    logic             cin_msb_q;
    logic [CW-1:0]    cnt_q;

    logic             start_ready_q;
    logic             busy_q;
    logic             res_valid_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             ovf_q;

    // Full-adder cell and shift-path next values
    logic             s_bit;
    logic             carry_d;
    logic             last_shift;
    logic             cin_msb_d;
    logic [WIDTH-1:0] psum_d;

    always_comb begin
        s_bit      = a_sh_q[0] ^ b_sh_q[0] ^ carry_q;
        carry_d    = (a_sh_q[0] & b_sh_q[0]) | (a_sh_q[0] & carry_q) | (b_sh_q[0] & carry_q);
        last_shift = (cnt_q == CW'(WIDTH - 1));
        // The carry entering the MSB is the carry held while the MSB is processed.
        // It is forwarded here so that the overflow can be formed on the same edge.
        cin_msb_d  = last_shift ? carry_q : cin_msb_q;
        psum_d     = {s_bit, psum_q[WIDTH-1:1]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            a_sh_q        <= '0;
            b_sh_q        <= '0;
            psum_q        <= '0;
            carry_q       <= 1'b0;
            cin_msb_q     <= 1'b0;
            cnt_q         <= '0;
            start_ready_q <= 1'b1;
            busy_q        <= 1'b0;
            res_valid_q   <= 1'b0;
            sum_q         <= '0;
            cout_q        <= 1'b0;
            ovf_q         <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start_valid) begin
                        a_sh_q        <= bus.a_in;
                        // Subtract is A + ~B + 1. The +1 enters as the initial carry.
                        b_sh_q        <= bus.b_in ^ {WIDTH{bus.control}};
                        carry_q       <= bus.control;
                        cnt_q         <= '0;
                        state_q       <= SHIFT;
                        start_ready_q <= 1'b0;
                        busy_q        <= 1'b1;
                    end
                end

                SHIFT: begin
                    a_sh_q    <= {1'b0, a_sh_q[WIDTH-1:1]};
                    b_sh_q    <= {1'b0, b_sh_q[WIDTH-1:1]};
                    psum_q    <= psum_d;
                    carry_q   <= carry_d;
                    cin_msb_q <= cin_msb_d;
                    cnt_q     <= cnt_q + 1'b1;
                    if (last_shift) begin
                        state_q     <= DONE;
                        res_valid_q <= 1'b1;
                        sum_q       <= psum_d;
                        cout_q      <= carry_d;
                        ovf_q       <= cin_msb_d ^ carry_d;
                    end
                end

                DONE: begin
                    // Result outputs are held until the consumer accepts them.
                    // IDLE is then re-entered without a same-edge accept.
                    if (bus.res_ready) begin
                        state_q       <= IDLE;
                        res_valid_q   <= 1'b0;
                        busy_q        <= 1'b0;
                        start_ready_q <= 1'b1;
                    end
                end

                default: begin
                    state_q       <= IDLE;
                    res_valid_q   <= 1'b0;
                    busy_q        <= 1'b0;
                    start_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign bus.start_ready = start_ready_q;
    assign bus.busy        = busy_q;
    assign bus.res_valid   = res_valid_q;
    assign bus.sum_out     = sum_q;
    assign bus.cout_out    = cout_q;
    assign bus.ovf_out     = ovf_q;

endmodule

// File: tb/tb_serial_addsub_ctrl.sv
module tb_serial_addsub_ctrl;
    localparam int W = 4;

    logic clk;
    logic rst_n;

    serial_addsub_ctrl_if #(.WIDTH(W)) bus_if ();

    serial_addsub_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: integer arithmetic, independent of the serial datapath
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic ctl);
        exp_t        e;
        logic [W:0]  t;
        int          sa;
        int          sb;
        int          r;
        t  = ctl ? ({1'b0, a} + {1'b0, ~b} + (W+1)'(1)) : ({1'b0, a} + {1'b0, b});
        sa = int'($signed(a));
        sb = int'($signed(b));
        r  = ctl ? (sa - sb) : (sa + sb);
        e.sum  = t[W-1:0];
        e.cout = t[W];
        e.ovf  = (r < -(2 ** (W - 1))) || (r > (2 ** (W - 1) - 1));
        return e;
    endfunction

    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic ctl);
        @(negedge clk);
        check("start_ready_idle", bus_if.start_ready, 1);
        bus_if.a_in        = a;
        bus_if.b_in        = b;
        bus_if.control     = ctl;
        bus_if.start_valid = 1'b1;
        sb_q.push_back(model(a, b, ctl));
        @(posedge clk);
        #1;
        check("busy_after_accept", bus_if.busy, 1);
        check("start_ready_after_accept", bus_if.start_ready, 0);
        @(negedge clk);
        bus_if.start_valid = 1'b0;
    endtask

    // Bounded wait of exactly WIDTH edges. This also checks the latency.
    task automatic wait_result(input bit churn);
        exp_t e;
        for (int i = 1; i <= W; i++) begin
            if (churn && i > 1) begin
                @(negedge clk);
                bus_if.a_in    = W'($urandom);
                bus_if.b_in    = W'($urandom);
                bus_if.control = 1'($urandom);
            end
            @(posedge clk);
            #1;
            check("res_valid_latency", bus_if.res_valid, (i == W) ? 1 : 0);
        end
        e = sb_q.pop_front();
        $display("result: sum=%b cout=%b ovf=%b (expected %b %b %b)",
                 bus_if.sum_out, bus_if.cout_out, bus_if.ovf_out, e.sum, e.cout, e.ovf);
        check("sum", bus_if.sum_out, e.sum);
        check("cout", bus_if.cout_out, e.cout);
        check("ovf", bus_if.ovf_out, e.ovf);
        sb_q.push_front(e);
    endtask

    task automatic accept_result();
        @(negedge clk);
        bus_if.res_ready = 1'b1;
        @(posedge clk);
        #1;
        check("res_valid_cleared", bus_if.res_valid, 0);
        check("start_ready_back", bus_if.start_ready, 1);
        check("busy_cleared", bus_if.busy, 0);
        void'(sb_q.pop_front());
        @(negedge clk);
        bus_if.res_ready = 1'b0;
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic ctl);
        start_op(a, b, ctl);
        wait_result(1'b0);
        accept_result();
    endtask

    initial begin
        exp_t e;
        bus_if.start_valid = 1'b0;
        bus_if.a_in        = '0;
        bus_if.b_in        = '0;
        bus_if.control     = 1'b0;
        bus_if.res_ready   = 1'b0;
        rst_n              = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_start_ready", bus_if.start_ready, 1);
        check("rst_busy", bus_if.busy, 0);
        check("rst_res_valid", bus_if.res_valid, 0);
        check("rst_sum", bus_if.sum_out, 0);
        check("rst_cout", bus_if.cout_out, 0);
        check("rst_ovf", bus_if.ovf_out, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed add/sub and wrap cases
        run_op(4'b0001, 4'b1010, 1'b0);
        run_op(4'b1010, 4'b0010, 1'b1);
        run_op(4'b1111, 4'b0101, 1'b1);
        run_op(4'b0111, 4'b0001, 1'b0);
        run_op(4'b1111, 4'b0001, 1'b0);
        run_op(4'b0000, 4'b0001, 1'b1);
        run_op(4'b1000, 4'b0001, 1'b1);

        // Backpressure with ignored start pulses
        start_op(4'b0101, 4'b0110, 1'b0);
        wait_result(1'b0);
        e = sb_q[0];
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus_if.start_valid = 1'b1;
            bus_if.a_in        = 4'b1111;
            bus_if.b_in        = 4'b1111;
            @(posedge clk);
            #1;
            check("bp_res_valid", bus_if.res_valid, 1);
            check("bp_start_ready", bus_if.start_ready, 0);
            check("bp_sum", bus_if.sum_out, e.sum);
            check("bp_ovf", bus_if.ovf_out, e.ovf);
        end
        @(negedge clk);
        bus_if.start_valid = 1'b0;
        accept_result();
        @(posedge clk);
        #1;
        check("bp_no_stray_accept", bus_if.busy, 0);
        check("hold_sum_idle", bus_if.sum_out, e.sum);

        // Input churn during SHIFT
        start_op(4'b0110, 4'b0011, 1'b1);
        wait_result(1'b1);
        accept_result();
        start_op(4'b1001, 4'b0100, 1'b0);
        wait_result(1'b1);
        accept_result();

        // Asynchronous reset mid-SHIFT (cnt=2)
        start_op(4'b0010, 4'b0001, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_rst_busy", bus_if.busy, 0);
        check("async_rst_start_ready", bus_if.start_ready, 1);
        check("async_rst_res_valid", bus_if.res_valid, 0);
        check("async_rst_sum", bus_if.sum_out, 0);
        check("async_rst_cout", bus_if.cout_out, 0);
        check("async_rst_ovf", bus_if.ovf_out, 0);
        void'(sb_q.pop_back());
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_no_res_valid", bus_if.res_valid, 0);
        run_op(4'b0011, 4'b0100, 1'b0);

        check("scoreboard_empty", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Absolute time limit so the run always ends
    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
